// File: rtl/mini_cpu_param_if.sv
// Host-side bus of the accumulator CPU: instruction/operand handshake plus result port.
// Handshake: an instruction transfers on a rising clk edge where instr_valid && instr_ready;
// the host holds instr/din stable while instr_valid is high and ready is low.
interface mini_cpu_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              instr_valid;
  logic              instr_ready;
  logic [ADDR_W+3:0] instr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              busy;
  logic [1:0]        state_dbg;

  modport master (
    output instr_valid, instr, din,
    input  instr_ready, dout, dout_valid, busy, state_dbg
  );

  modport slave (
    input  instr_valid, instr, din,
    output instr_ready, dout, dout_valid, busy, state_dbg
  );
endinterface

// File: rtl/mini_cpu_param.sv
// Accumulator-style CPU core: registers A/B/C, ALU, single-port RAM, FETCH/EXEC/MEMWB FSM.
// Optional zero/carry flags are built when MINI_CPU_FLAGS_EN is defined.
module mini_cpu_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  mini_cpu_param_if.slave   bus
`ifdef MINI_CPU_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_c
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEMWB = 2'd2
  } state_t;

  localparam logic [3:0] OP_SUB    = 4'h0;
  localparam logic [3:0] OP_ADD    = 4'h1;
  localparam logic [3:0] OP_INC    = 4'h2;
  localparam logic [3:0] OP_DEC    = 4'h3;
  localparam logic [3:0] OP_ADDDEC = 4'h4;
  localparam logic [3:0] OP_MOVA   = 4'h5;
  localparam logic [3:0] OP_LDA    = 4'h6;
  localparam logic [3:0] OP_LDB    = 4'h7;
  localparam logic [3:0] OP_STI    = 4'h8;
  localparam logic [3:0] OP_STC    = 4'h9;
  localparam logic [3:0] OP_LDC    = 4'hA;
  localparam logic [3:0] OP_OUT    = 4'hB;
  localparam logic [3:0] OP_MCA    = 4'hC;
  localparam logic [3:0] OP_MCB    = 4'hD;

  localparam int          DEPTH  = 2 ** ADDR_W;
  localparam logic [DATA_W:0] ONE_X = {{DATA_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic [3:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   c_q, c_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
`ifdef MINI_CPU_FLAGS_EN
  logic                flag_z_q, flag_z_d;
  logic                flag_c_q, flag_c_d;
`endif

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_q;
  logic                mem_we;
  logic                mem_re;
  logic [DATA_W-1:0]   mem_wdata;

  logic                accept;
  logic [DATA_W:0]     sum_ab;
  logic [DATA_W:0]     alu_ext;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                alu_op;

  assign accept = bus.instr_valid && ready_q;
  assign sum_ab = {1'b0, a_q} + {1'b0, b_q};

  // Extra top bit carries carry-out on additions and borrow on subtractions.
  always_comb begin
    alu_ext = {1'b0, a_q};
    alu_c   = 1'b0;
    alu_op  = 1'b0;
    case (op_q)
      OP_SUB: begin
        alu_ext = {1'b0, a_q} - {1'b0, b_q};
        alu_c   = alu_ext[DATA_W];
        alu_op  = 1'b1;
      end
      OP_ADD: begin
        alu_ext = sum_ab;
        alu_c   = alu_ext[DATA_W];
        alu_op  = 1'b1;
      end
      OP_INC: begin
        alu_ext = {1'b0, a_q} + ONE_X;
        alu_c   = alu_ext[DATA_W];
        alu_op  = 1'b1;
      end
      OP_DEC: begin
        alu_ext = {1'b0, a_q} - ONE_X;
        alu_c   = alu_ext[DATA_W];
        alu_op  = 1'b1;
      end
      OP_ADDDEC: begin
        // Carry only when A+B-1 still exceeds the word, i.e. A+B > 2**DATA_W.
        alu_ext = sum_ab - ONE_X;
        alu_c   = sum_ab[DATA_W] && (sum_ab[DATA_W-1:0] != '0);
        alu_op  = 1'b1;
      end
      OP_MOVA: begin
        alu_ext = {1'b0, a_q};
        alu_c   = 1'b0;
        alu_op  = 1'b1;
      end
      default: begin
        alu_ext = {1'b0, a_q};
        alu_c   = 1'b0;
        alu_op  = 1'b0;
      end
    endcase
    alu_res = alu_ext[DATA_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    op_d         = op_q;
    addr_d       = addr_q;
    din_d        = din_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_wdata    = din_q;
`ifdef MINI_CPU_FLAGS_EN
    flag_z_d     = flag_z_q;
    flag_c_d     = flag_c_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (accept) begin
          op_d    = bus.instr[ADDR_W+3:ADDR_W];
          addr_d  = bus.instr[ADDR_W-1:0];
          din_d   = bus.din;
          state_d = S_EXEC;
          ready_d = 1'b0;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        ready_d = 1'b1;
        if (alu_op) begin
          c_d = alu_res;
`ifdef MINI_CPU_FLAGS_EN
          flag_z_d = (alu_res == '0);
          flag_c_d = alu_c;
`endif
        end
        case (op_q)
          OP_LDA: a_d = din_q;
          OP_LDB: b_d = din_q;
          OP_STI: begin
            mem_we    = 1'b1;
            mem_wdata = din_q;
          end
          OP_STC: begin
            mem_we    = 1'b1;
            mem_wdata = c_q;
          end
          OP_LDC: begin
            mem_re  = 1'b1;
            state_d = S_MEMWB;
            ready_d = 1'b0;
          end
          OP_OUT: begin
            dout_d       = c_q;
            dout_valid_d = 1'b1;
          end
          OP_MCA: a_d = c_q;
          OP_MCB: b_d = c_q;
          default: ;
        endcase
      end
      S_MEMWB: begin
        c_d     = rd_q;
        state_d = S_FETCH;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      ready_q      <= 1'b1;
      op_q         <= 4'hF;
      addr_q       <= '0;
      din_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
`ifdef MINI_CPU_FLAGS_EN
      flag_z_q     <= 1'b0;
      flag_c_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
`ifdef MINI_CPU_FLAGS_EN
      flag_z_q     <= flag_z_d;
      flag_c_q     <= flag_c_d;
`endif
    end
  end

  // RAM contents survive reset; only a write landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[addr_q] <= mem_wdata;
    end
    if (mem_re) begin
      rd_q <= mem[addr_q];
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.busy        = ~ready_q;
  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.state_dbg   = state_q;
`ifdef MINI_CPU_FLAGS_EN
  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
`endif

endmodule

// File: tb/tb_mini_cpu_param.sv
// Bench for mini_cpu_param: an 8/4 instance and a 16/6 instance driven by directed vectors,
// with OUT results checked by a queue-based monitor.
module tb_mini_cpu_param;

  localparam logic [3:0] SUB = 4'h0, ADD = 4'h1, INC = 4'h2, DEC = 4'h3, ADDDEC = 4'h4,
                         MOVA = 4'h5, LDA = 4'h6, LDB = 4'h7, STI = 4'h8, STC = 4'h9,
                         LDC = 4'hA, OUT = 4'hB, MCA = 4'hC, MCB = 4'hD, NOP = 4'hE;

  // clock / reset
  logic clk = 1'b0;
  logic reset8;
  logic reset16;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mini_cpu_param_if #(.DATA_W(8),  .ADDR_W(4)) bus8 ();
  mini_cpu_param_if #(.DATA_W(16), .ADDR_W(6)) bus16 ();

`ifdef MINI_CPU_FLAGS_EN
  logic fz8, fc8, fz16, fc16;
`endif

  mini_cpu_param #(.DATA_W(8), .ADDR_W(4)) dut8 (
    .clk   (clk),
    .reset (reset8),
    .bus   (bus8)
`ifdef MINI_CPU_FLAGS_EN
    ,
    .flag_z(fz8),
    .flag_c(fc8)
`endif
  );

  mini_cpu_param #(.DATA_W(16), .ADDR_W(6)) dut16 (
    .clk   (clk),
    .reset (reset16),
    .bus   (bus16)
`ifdef MINI_CPU_FLAGS_EN
    ,
    .flag_z(fz16),
    .flag_c(fc16)
`endif
  );

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  exp8_q[$];
  logic [15:0] exp16_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: pops an expectation on each dout_valid pulse
  logic prev8 = 1'b0;
  logic prev16 = 1'b0;
  always @(negedge clk) begin
    if (bus8.dout_valid === 1'b1) begin
      check("dout8_pulse_width", {31'd0, prev8}, 32'd0);
      if (exp8_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dout8_unexpected: got 0x%0h, expected no output", bus8.dout);
      end else begin
        check("dout8", {24'd0, bus8.dout}, {24'd0, exp8_q.pop_front()});
      end
    end
    prev8 = bus8.dout_valid;
    if (bus16.dout_valid === 1'b1) begin
      check("dout16_pulse_width", {31'd0, prev16}, 32'd0);
      if (exp16_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dout16_unexpected: got 0x%0h, expected no output", bus16.dout);
      end else begin
        check("dout16", {16'd0, bus16.dout}, {16'd0, exp16_q.pop_front()});
      end
    end
    prev16 = bus16.dout_valid;
  end

  // driver tasks
  task automatic send8(input logic [3:0] op, input logic [3:0] addr, input logic [7:0] d,
                       output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (bus8.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_cmp++;
      n_err++;
      $display("FAIL send8_timeout: instr_ready stuck at %b, expected 1", bus8.instr_ready);
    end
    bus8.instr_valid = 1'b1;
    bus8.instr       = {op, addr};
    bus8.din         = d;
    @(posedge clk);
    #1;
    bus8.instr_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic send16(input logic [3:0] op, input logic [5:0] addr, input logic [15:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (bus16.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_cmp++;
      n_err++;
      $display("FAIL send16_timeout: instr_ready stuck at %b, expected 1", bus16.instr_ready);
    end
    bus16.instr_valid = 1'b1;
    bus16.instr       = {op, addr};
    bus16.din         = d;
    @(posedge clk);
    #1;
    bus16.instr_valid = 1'b0;
  endtask

  task automatic wait_idle8();
    int n;
    n = 0;
    @(negedge clk);
    while (bus8.instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle8_timeout: instr_ready stuck at %b, expected 1", bus8.instr_ready);
    end
  endtask

  // stimulus
  initial begin
    int t0, t1, t2, t3;
    reset8  = 1'b1;
    reset16 = 1'b1;
    bus8.instr_valid  = 1'b0;
    bus8.instr        = '0;
    bus8.din          = '0;
    bus16.instr_valid = 1'b0;
    bus16.instr       = '0;
    bus16.din         = '0;
    repeat (2) @(posedge clk);
    #1;
    reset8  = 1'b0;
    reset16 = 1'b0;

    // reset state
    check("rst_ready8",      {31'd0, bus8.instr_ready}, 32'd1);
    check("rst_busy8",       {31'd0, bus8.busy},        32'd0);
    check("rst_dout8",       {24'd0, bus8.dout},        32'd0);
    check("rst_dout_valid8", {31'd0, bus8.dout_valid},  32'd0);
    check("rst_state8",      {30'd0, bus8.state_dbg},   32'd0);
    check("rst_ready16",     {31'd0, bus16.instr_ready}, 32'd1);
`ifdef MINI_CPU_FLAGS_EN
    check("rst_flag_z", {31'd0, fz8}, 32'd0);
    check("rst_flag_c", {31'd0, fc8}, 32'd0);
`endif
    // C=0 and A+B=0 straight after reset
    exp8_q.push_back(8'h00);
    send8(OUT, 4'h0, 8'h00, t0);
    send8(ADD, 4'h0, 8'h00, t0);
    exp8_q.push_back(8'h00);
    send8(OUT, 4'h0, 8'h00, t0);

    // LDA/LDB/ADD/OUT, accept spacing
    send8(LDA, 4'h0, 8'h05, t0);
    send8(LDB, 4'h0, 8'h03, t1);
    send8(ADD, 4'h0, 8'h00, t2);
    exp8_q.push_back(8'h08);
    send8(OUT, 4'h0, 8'h00, t3);
    check("gap_lda_ldb", t1 - t0, 32'd2);
    check("gap_ldb_add", t2 - t1, 32'd2);
    check("gap_add_out", t3 - t2, 32'd2);

    // INC wrap, SUB borrow
    send8(LDA, 4'h0, 8'hFF, t0);
    send8(INC, 4'h0, 8'h00, t0);
    exp8_q.push_back(8'h00);
    send8(OUT, 4'h0, 8'h00, t0);
    wait_idle8();
`ifdef MINI_CPU_FLAGS_EN
    check("inc_flag_z", {31'd0, fz8}, 32'd1);
    check("inc_flag_c", {31'd0, fc8}, 32'd1);
`endif
    send8(LDA, 4'h0, 8'h02, t0);
    send8(LDB, 4'h0, 8'h03, t0);
    send8(SUB, 4'h0, 8'h00, t0);
    exp8_q.push_back(8'hFF);
    send8(OUT, 4'h0, 8'h00, t0);
    wait_idle8();
`ifdef MINI_CPU_FLAGS_EN
    check("sub_flag_z", {31'd0, fz8}, 32'd0);
    check("sub_flag_c", {31'd0, fc8}, 32'd1);
`endif

    // ADDDEC, MCB, NOP, MCA, DEC
    send8(LDA, 4'h0, 8'h10, t0);
    send8(LDB, 4'h0, 8'h07, t0);
    send8(ADDDEC, 4'h0, 8'h00, t0);
    exp8_q.push_back(8'h16);
    send8(OUT, 4'h0, 8'h00, t0);
    send8(MCB, 4'h0, 8'h00, t0);
    send8(LDA, 4'h0, 8'h20, t0);
    send8(SUB, 4'h0, 8'h00, t0);
    exp8_q.push_back(8'h0A);
    send8(OUT, 4'h0, 8'h00, t0);
    send8(NOP, 4'h0, 8'h55, t0);
    exp8_q.push_back(8'h0A);
    send8(OUT, 4'h0, 8'h00, t0);
    send8(MCA, 4'h0, 8'h00, t0);
    send8(DEC, 4'h0, 8'h00, t0);
    exp8_q.push_back(8'h09);
    send8(OUT, 4'h0, 8'h00, t0);
    send8(LDA, 4'h0, 8'h00, t0);
    send8(DEC, 4'h0, 8'h00, t0);
    exp8_q.push_back(8'hFF);
    send8(OUT, 4'h0, 8'h00, t0);
    send8(LDA, 4'h0, 8'h42, t0);
    send8(MOVA, 4'h0, 8'h00, t0);
    exp8_q.push_back(8'h42);
    send8(OUT, 4'h0, 8'h00, t0);

    // STI/LDC round trip, LDC occupancy
    send8(STI, 4'h3, 8'hA5, t0);
    send8(LDC, 4'h3, 8'h00, t1);
    @(negedge clk);
    check("ldc_ready_exec", {31'd0, bus8.instr_ready}, 32'd0);
    @(negedge clk);
    check("ldc_ready_memwb", {31'd0, bus8.instr_ready}, 32'd0);
    check("ldc_state_memwb", {30'd0, bus8.state_dbg},  32'd2);
    exp8_q.push_back(8'hA5);
    send8(OUT, 4'h0, 8'h00, t2);
    check("gap_ldc_out", t2 - t1, 32'd3);

    // STC then LDC at top address
    send8(LDA, 4'h0, 8'h3C, t0);
    send8(MOVA, 4'h0, 8'h00, t0);
    send8(STC, 4'hF, 8'h00, t0);
    send8(LDA, 4'h0, 8'h00, t0);
    send8(MOVA, 4'h0, 8'h00, t0);
    send8(LDC, 4'hF, 8'h00, t0);
    exp8_q.push_back(8'h3C);
    send8(OUT, 4'h0, 8'h00, t0);

    // reset during MEMWB aborts LDC, RAM kept
    send8(LDC, 4'h3, 8'h00, t0);
    @(posedge clk);
    #1;
    check("abort_state_memwb", {30'd0, bus8.state_dbg}, 32'd2);
    reset8 = 1'b1;
    @(posedge clk);
    #1;
    reset8 = 1'b0;
    check("abort_state", {30'd0, bus8.state_dbg},   32'd0);
    check("abort_ready", {31'd0, bus8.instr_ready}, 32'd1);
    check("abort_dout",  {24'd0, bus8.dout},        32'd0);
    exp8_q.push_back(8'h00);
    send8(OUT, 4'h0, 8'h00, t0);
    send8(LDC, 4'h3, 8'h00, t0);
    exp8_q.push_back(8'hA5);
    send8(OUT, 4'h0, 8'h00, t0);

    // reset during EXEC of STI suppresses the write
    send8(STI, 4'h5, 8'h11, t0);
    send8(STI, 4'h5, 8'h77, t0);
    reset8 = 1'b1;
    @(posedge clk);
    #1;
    reset8 = 1'b0;
    send8(LDC, 4'h5, 8'h00, t0);
    exp8_q.push_back(8'h11);
    send8(OUT, 4'h0, 8'h00, t0);

    // dout holds after the pulse
    wait_idle8();
    repeat (3) @(negedge clk);
    check("dout_hold",       {24'd0, bus8.dout},       32'h11);
    check("dout_valid_idle", {31'd0, bus8.dout_valid}, 32'd0);

    // wide instance
    send16(LDA, 6'd0, 16'h0000);
    send16(LDB, 6'd0, 16'h0001);
    send16(SUB, 6'd0, 16'h0000);
    exp16_q.push_back(16'hFFFF);
    send16(OUT, 6'd0, 16'h0000);
    send16(STI, 6'd63, 16'h1234);
    send16(LDC, 6'd63, 16'h0000);
    exp16_q.push_back(16'h1234);
    send16(OUT, 6'd0, 16'h0000);
    send16(LDA, 6'd0, 16'hFFFF);
    send16(LDB, 6'd0, 16'h0002);
    send16(ADD, 6'd0, 16'h0000);
    exp16_q.push_back(16'h0001);
    send16(OUT, 6'd0, 16'h0000);

    repeat (6) @(negedge clk);
    check("exp8_drained",  exp8_q.size(),  32'd0);
    check("exp16_drained", exp16_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
